// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg
// Shared definitions for the fetch stage: error-flag bit positions,
// the fetch-slot state type and the ROM address-width derivation.
package instr_fetch_pkg;

    localparam int ERR_STK_OVF = 0;
    localparam int ERR_STK_UNF = 1;
    localparam int ERR_BAD_TGT = 2;
    localparam int ERR_MULTI   = 3;
    localparam int ERR_W       = 4;

    typedef enum logic {
        FETCH_EMPTY = 1'b0,
        FETCH_FULL  = 1'b1
    } fetch_state_t;

    // Address width for a ROM of 'depth' words; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/instr_fetch_ret_stack.sv
// ret_stack
// Return-address LIFO of SDEPTH entries, AW bits each.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset (empties the stack)
//   push, din - write din on top; ignored when full
//   pop       - discard top entry; ignored when empty
//   top       - current top entry (0 when empty)
//   full      - SDEPTH entries held
//   empty     - no entries held
module ret_stack #(
    parameter int SDEPTH = 4,
    parameter int AW     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] top,
    output logic          full,
    output logic          empty
);

    localparam int SPW = $clog2(SDEPTH + 1);

    logic [SPW-1:0] sp;
    logic [AW-1:0]  mem [SDEPTH];

    assign full  = (sp == SPW'(SDEPTH));
    assign empty = (sp == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end

    // Entry contents need no reset: sp alone decides what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SDEPTH; i++) begin
            if (push && !full && (sp == SPW'(i))) begin
                mem[i] <= din;
            end
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < SDEPTH; i++) begin
            if (sp == SPW'(i + 1)) begin
                top = mem[i];
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
// Program counter and fetch stage. Drives the instruction ROM address
// combinationally from this cycle's decision so redirects cost no bubble;
// the ROM's registered read returns the word on the next edge.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   addr         - ROM read address (combinational)
//   data         - ROM read data, one cycle after addr
//   instr, pc    - fetched word and its address, to the decoder
//   valid, ready - fetch/decoder handshake
//   jmp/cal/ret  - redirect requests, honoured only on accept
//   tgt          - jump/call target
//   err          - sticky {multi_redirect, bad_tgt, stk_unf, stk_ovf}
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int  NADDRE = 8,
    parameter int  NBDATA = 12,
    parameter int  SDEPTH = 4,
    localparam int AW     = addr_width(NADDRE)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [AW-1:0]     addr,
    input  logic [NBDATA-1:0] data,
    output logic [NBDATA-1:0] instr,
    output logic [AW-1:0]     pc,
    output logic              valid,
    input  logic              ready,
    input  logic              jmp,
    input  logic              cal,
    input  logic              ret,
    input  logic [AW-1:0]     tgt,
    output logic [ERR_W-1:0]  err
);

    localparam int AWX = AW + 1;

    fetch_state_t     state;
    logic [AW-1:0]    nxt;
    logic [AW-1:0]    tgt_eff;
    logic             tgt_ok;
    logic             accept;
    logic             push;
    logic             pop;
    logic [AW-1:0]    stk_top;
    logic             stk_full;
    logic             stk_empty;
    logic [ERR_W-1:0] err_set;

    assign accept  = (state == FETCH_FULL) && ready;
    assign nxt     = (pc == AW'(NADDRE - 1)) ? '0 : pc + AW'(1);
    assign tgt_ok  = ({1'b0, tgt} < AWX'(NADDRE));
    assign tgt_eff = tgt_ok ? tgt : '0;

    // Redirect decision; priority ret > cal > jmp. Outside an accept the
    // address stays on pc so the ROM re-reads the same word.
    always_comb begin
        addr    = pc;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = '0;
        if (!rst) begin
            addr = '0;
        end else if (accept) begin
            if (ret) begin
                if (stk_empty) begin
                    addr                 = nxt;
                    err_set[ERR_STK_UNF] = 1'b1;
                end else begin
                    addr = stk_top;
                    pop  = 1'b1;
                end
            end else if (cal) begin
                addr                 = tgt_eff;
                push                 = 1'b1;
                err_set[ERR_BAD_TGT] = !tgt_ok;
                err_set[ERR_STK_OVF] = stk_full;
            end else if (jmp) begin
                addr                 = tgt_eff;
                err_set[ERR_BAD_TGT] = !tgt_ok;
            end else begin
                addr = nxt;
            end
            err_set[ERR_MULTI] = (ret & cal) | (ret & jmp) | (cal & jmp);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= '0;
            state <= FETCH_EMPTY;
            err   <= '0;
        end else begin
            pc    <= addr;
            state <= FETCH_FULL;
            err   <= err | err_set;
        end
    end

    assign valid = (state == FETCH_FULL);
    assign instr = data;

    ret_stack #(
        .SDEPTH (SDEPTH),
        .AW     (AW)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (nxt),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
// ROM depth 6 leaves targets 6 and 7 representable on the 3-bit tgt port,
// so out-of-range jumps and calls can actually be driven.
module tb_instr_fetch;

    localparam int NADDRE = 6;
    localparam int NBDATA = 12;
    localparam int SDEPTH = 2;
    localparam int AW     = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [AW-1:0]     addr;
    logic [NBDATA-1:0] data = '0;
    logic [NBDATA-1:0] instr;
    logic [AW-1:0]     pc;
    logic              valid;
    logic              ready = 1'b0;
    logic              jmp = 1'b0;
    logic              cal = 1'b0;
    logic              ret = 1'b0;
    logic [AW-1:0]     tgt = '0;
    logic [3:0]        err;

    logic [NBDATA-1:0] rom [NADDRE];

    int n_chk  = 0;
    int n_pass = 0;

    // reference state
    int         m_pc    = 0;
    bit         m_valid = 1'b0;
    logic [3:0] m_err   = '0;
    int         stk[$];

    instr_fetch #(
        .NADDRE (NADDRE),
        .NBDATA (NBDATA),
        .SDEPTH (SDEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .data  (data),
        .instr (instr),
        .pc    (pc),
        .valid (valid),
        .ready (ready),
        .jmp   (jmp),
        .cal   (cal),
        .ret   (ret),
        .tgt   (tgt),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (int'(addr) < NADDRE) data <= rom[addr];
        else                     data <= '0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // One clock cycle: drive inputs, predict and check addr, then after
    // the edge check everything the decoder sees.
    task automatic step(input bit r, input bit j, input bit c, input bit rt, input int tg);
        int         npc;
        int         n;
        int         t;
        logic [3:0] nerr;
        int         q[$];
        ready = r; jmp = j; cal = c; ret = rt; tgt = AW'(tg);
        npc  = m_pc;
        nerr = m_err;
        q    = stk;
        if (m_valid && r) begin
            n = (m_pc + 1) % NADDRE;
            t = (tg < NADDRE) ? tg : 0;
            if (int'(j) + int'(c) + int'(rt) > 1) nerr[3] = 1'b1;
            if (rt) begin
                if (q.size() == 0) begin
                    npc = n;
                    nerr[1] = 1'b1;
                end else begin
                    npc = q.pop_back();
                end
            end else if (c) begin
                npc = t;
                if (tg >= NADDRE) nerr[2] = 1'b1;
                if (q.size() == SDEPTH) nerr[0] = 1'b1;
                else q.push_back(n);
            end else if (j) begin
                npc = t;
                if (tg >= NADDRE) nerr[2] = 1'b1;
            end else begin
                npc = n;
            end
        end
        #1;
        check("addr", 32'(addr), 32'(npc));
        @(posedge clk);
        m_pc    = npc;
        m_valid = 1'b1;
        m_err   = nerr;
        stk     = q;
        @(negedge clk);
        check("valid", 32'(valid), 32'(m_valid));
        check("pc", 32'(pc), 32'(m_pc));
        check("instr", 32'(instr), 32'(rom[m_pc]));
        check("err", 32'(err), 32'(m_err));
    endtask

    // Called just after a falling edge; asserts reset mid-cycle and
    // releases it on the next falling edge.
    task automatic do_reset();
        ready = 1'b0; jmp = 1'b0; cal = 1'b0; ret = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        m_pc = 0; m_valid = 1'b0; m_err = '0; stk.delete();
        @(negedge clk);
        rst = 1'b1;
        #1 check("empty_valid", 32'(valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NADDRE; i++) rom[i] = NBDATA'($urandom);
        @(negedge clk);
        do_reset();

        // sequential run with wrap
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 0, 0, 0);
            check("wrap_pc", 32'(pc), 32'(i % NADDRE));
        end
        // stall at pc=3, jump during stall ignored
        step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            check("stall_pc", 32'(pc), 32'd3);
        end
        step(0, 1, 0, 0, 5);
        check("stall_jmp", 32'(pc), 32'd3);
        step(1, 0, 0, 0, 0);
        check("resume_pc", 32'(pc), 32'd4);
        step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 5);
        check("jmp_pc", 32'(pc), 32'd5);

        // call/return nesting and underflow
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 4); check("cal1_pc", 32'(pc), 32'd4);
        step(1, 0, 1, 0, 2); check("cal2_pc", 32'(pc), 32'd2);
        step(1, 0, 0, 1, 0); check("ret1_pc", 32'(pc), 32'd5);
        step(1, 0, 0, 1, 0); check("ret2_pc", 32'(pc), 32'd1);
        step(1, 0, 0, 1, 0); check("unf_pc", 32'(pc), 32'd2);
        check("unf_bit", 32'(err[1]), 32'd1);

        // overflow, multi-redirect, bad target, mid-stream reset
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 3);
        step(1, 0, 1, 0, 5);
        step(1, 0, 1, 0, 2); check("ovf_pc", 32'(pc), 32'd2);
        check("ovf_bit", 32'(err[0]), 32'd1);
        step(1, 0, 0, 1, 0); check("ovf_ret1", 32'(pc), 32'd4);
        step(1, 0, 0, 1, 0); check("ovf_ret2", 32'(pc), 32'd1);
        step(1, 1, 1, 0, 4); check("multi_pc", 32'(pc), 32'd4);
        check("multi_bit", 32'(err[3]), 32'd1);
        step(1, 1, 0, 0, 7); check("bad_pc", 32'(pc), 32'd0);
        check("bad_bit", 32'(err[2]), 32'd1);
        step(1, 0, 0, 0, 0);
        do_reset();

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            if (k % 150 == 149) do_reset();
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 4) == 0,
                 int'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
